// File: rtl/issue_sched_n.sv
// issue_sched_n: in-order multi-slot issue scheduler with a per-register countdown scoreboard,
// intra-group hazard checks, memory-port and branch limits, and a RUN/HALT state machine.
module issue_sched_n #(
    parameter int ISSUE_W   = 2,
    parameter int ALU_LAT   = 1,
    parameter int LD_LAT    = 2,
    parameter int MEM_PORTS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [ISSUE_W-1:0]     slot_valid,
    input  logic [5*ISSUE_W-1:0]   slot_rs1,
    input  logic [5*ISSUE_W-1:0]   slot_rs2,
    input  logic [5*ISSUE_W-1:0]   slot_rd,
    input  logic [ISSUE_W-1:0]     slot_use_rs1,
    input  logic [ISSUE_W-1:0]     slot_use_rs2,
    input  logic [ISSUE_W-1:0]     slot_reg_write,
    input  logic [ISSUE_W-1:0]     slot_mem_read,
    input  logic [ISSUE_W-1:0]     slot_mem_write,
    input  logic [ISSUE_W-1:0]     slot_branch,
    input  logic [ISSUE_W-1:0]     slot_system,
    output logic [ISSUE_W-1:0]     issue_mask,
    output logic [2:0]             issue_count,
    output logic                   stall_if,
    output logic [31:0]            busy_vec,
    output logic [31:0]            load_pending_vec,
    output logic                   halted
);
    typedef enum logic {RUN, HALT} state_t;

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_cnt [32];
    logic [31:0]        r_ld;
    logic               w_run;
    logic               w_chain;
    logic               w_sb, w_intra, w_struct;
    logic [2:0]         w_mem_cnt;
    logic [4:0]         w_rs1 [ISSUE_W];
    logic [4:0]         w_rs2 [ISSUE_W];
    logic [4:0]         w_rd  [ISSUE_W];
    logic [ISSUE_W-1:0] w_src1, w_src2, w_dst, w_mem, w_prev_br, w_hazard;

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
        assign w_rs1[k]  = slot_rs1[5*k +: 5];
        assign w_rs2[k]  = slot_rs2[5*k +: 5];
        assign w_rd[k]   = slot_rd[5*k +: 5];
        assign w_src1[k] = slot_use_rs1[k] && w_rs1[k] != 5'd0;
        assign w_src2[k] = slot_use_rs2[k] && w_rs2[k] != 5'd0;
        assign w_dst[k]  = slot_reg_write[k] && w_rd[k] != 5'd0;
        assign w_mem[k]  = slot_valid[k] & (slot_mem_read[k] | slot_mem_write[k]);
        if (k == 0) begin : g_first
            assign w_prev_br[k] = 1'b0;
        end else begin : g_rest
            assign w_prev_br[k] = slot_valid[k-1] & slot_branch[k-1];
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < 32; r++)
            busy_vec[r] = r_cnt[r] != 3'd0;
        load_pending_vec = r_ld & busy_vec;
    end

    // Slot 0 only waits on loads; younger slots see no forwarding, so any busy operand blocks.
    always_comb begin
        w_hazard  = '0;
        w_mem_cnt = '0;
        w_sb      = 1'b0;
        w_intra   = 1'b0;
        w_struct  = 1'b0;
        for (int k = 0; k < ISSUE_W; k++) begin
            w_mem_cnt = w_mem_cnt + {2'b0, w_mem[k]};
            w_sb = (k == 0) ? ((w_src1[k] & load_pending_vec[w_rs1[k]]) | (w_src2[k] & load_pending_vec[w_rs2[k]]))
                            : ((w_src1[k] & busy_vec[w_rs1[k]]) | (w_src2[k] & busy_vec[w_rs2[k]]) |
                               (w_dst[k] & busy_vec[w_rd[k]]));
            w_intra = 1'b0;
            for (int j = 0; j < ISSUE_W; j++)
                if (j < k)
                    w_intra = w_intra | (slot_valid[j] & (
                        (w_dst[j] & ((w_src1[k] & (w_rs1[k] == w_rd[j])) | (w_src2[k] & (w_rs2[k] == w_rd[j])) |
                                     (w_dst[k] & (w_rd[k] == w_rd[j])))) |
                        (w_dst[k] & ((slot_use_rs1[j] & (w_rs1[j] == w_rd[k])) |
                                     (slot_use_rs2[j] & (w_rs2[j] == w_rd[k]))))));
            w_struct = (w_mem_cnt > 3'(MEM_PORTS)) | w_prev_br[k] | ((k != 0) & slot_branch[k]);
            w_hazard[k] = w_struct | (!slot_system[k] & (w_sb | w_intra));
        end
    end

    always_comb begin
        issue_mask  = '0;
        issue_count = '0;
        w_chain     = w_run & !flush;
        for (int k = 0; k < ISSUE_W; k++) begin
            issue_mask[k] = w_chain & slot_valid[k] & !w_hazard[k];
            w_chain       = issue_mask[k];
            issue_count   = issue_count + {2'b0, issue_mask[k]};
        end
        stall_if = slot_valid[0] & !issue_mask[0] & w_run & !flush;
    end

    always_ff @(posedge clk)
        r_state <= rst ? RUN : w_state_nxt;

    always_comb
        w_state_nxt = (r_state == RUN && |(issue_mask & slot_system)) ? HALT : r_state;

    always_comb begin
        w_run  = r_state == RUN;
        halted = r_state == HALT;
    end

    // A fresh issue to a register overrides its same-edge decrement.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int r = 0; r < 32; r++)
                r_cnt[r] <= 3'd0;
            r_ld <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (r_cnt[r] != 3'd0)
                    r_cnt[r] <= r_cnt[r] - 3'd1;
                if (r_cnt[r] == 3'd1)
                    r_ld[r] <= 1'b0;
            end
            for (int k = 0; k < ISSUE_W; k++)
                if (issue_mask[k] && w_dst[k]) begin
                    r_cnt[w_rd[k]] <= slot_mem_read[k] ? 3'(LD_LAT) : 3'(ALU_LAT);
                    r_ld[w_rd[k]]  <= slot_mem_read[k];
                end
        end
    end
endmodule

// File: tb/tb_issue_sched_n.sv
// tb_issue_sched_n: directed issue-scheduler vectors; the driver queues hand-computed
// expectations and a negedge monitor pops and compares them.
module tb_issue_sched_n;
    localparam int W = 4;
    localparam int ALU = 0, LW = 1, SW = 2, BR = 3, SYS = 4;

    logic          clk = 1'b0;
    logic          rst, flush;
    logic [W-1:0]  slot_valid, slot_use_rs1, slot_use_rs2, slot_reg_write;
    logic [W-1:0]  slot_mem_read, slot_mem_write, slot_branch, slot_system;
    logic [5*W-1:0] slot_rs1, slot_rs2, slot_rd;
    logic [W-1:0]  issue_mask;
    logic [2:0]    issue_count;
    logic          stall_if, halted;
    logic [31:0]   busy_vec, load_pending_vec;

    typedef struct {
        logic [3:0]  m;
        logic [2:0]  c;
        logic        st;
        logic        sb;
        logic [31:0] b;
        logic [31:0] l;
        logic        h;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    issue_sched_n #(.ISSUE_W(W), .ALU_LAT(1), .LD_LAT(2), .MEM_PORTS(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .slot_valid(slot_valid), .slot_rs1(slot_rs1), .slot_rs2(slot_rs2), .slot_rd(slot_rd),
        .slot_use_rs1(slot_use_rs1), .slot_use_rs2(slot_use_rs2), .slot_reg_write(slot_reg_write),
        .slot_mem_read(slot_mem_read), .slot_mem_write(slot_mem_write), .slot_branch(slot_branch),
        .slot_system(slot_system), .issue_mask(issue_mask), .issue_count(issue_count),
        .stall_if(stall_if), .busy_vec(busy_vec), .load_pending_vec(load_pending_vec), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("issue_mask", 32'(issue_mask), 32'(e.m));
            chk("issue_count", 32'(issue_count), 32'(e.c));
            chk("stall_if", 32'(stall_if), 32'(e.st));
            if (e.sb) begin
                chk("busy_vec", busy_vec, e.b);
                chk("load_pending_vec", load_pending_vec, e.l);
                chk("halted", 32'(halted), 32'(e.h));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        slot_valid = '0; slot_use_rs1 = '0; slot_use_rs2 = '0; slot_reg_write = '0;
        slot_mem_read = '0; slot_mem_write = '0; slot_branch = '0; slot_system = '0;
        slot_rs1 = '0; slot_rs2 = '0; slot_rd = '0;
    endtask

    task automatic sl(input int k, input int kind, input int rd, input int rs1, input int rs2);
        slot_valid[k]     = 1'b1;
        slot_rd[5*k +: 5]  = 5'(rd);
        slot_rs1[5*k +: 5] = 5'(rs1);
        slot_rs2[5*k +: 5] = 5'(rs2);
        slot_use_rs1[k]   = kind != SYS;
        slot_use_rs2[k]   = kind == ALU || kind == SW || kind == BR;
        slot_reg_write[k] = kind == ALU || kind == LW;
        slot_mem_read[k]  = kind == LW;
        slot_mem_write[k] = kind == SW;
        slot_branch[k]    = kind == BR;
        slot_system[k]    = kind == SYS;
    endtask

    task automatic ex(input logic [3:0] m, input logic [2:0] c, input logic st, input logic sb,
                      input logic [31:0] b, input logic [31:0] l, input logic h);
        exp_t e;
        e.m = m; e.c = c; e.st = st; e.sb = sb; e.b = b; e.l = l; e.h = h;
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; clr();
        cyc(); cyc();
        rst = 1'b0;
        ex(4'b0000, 3'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        // RAW within the group: x5 produced by slot 0, read by slot 1
        cyc(); clr(); sl(0, ALU, 5, 1, 2); sl(1, ALU, 6, 5, 1);
        ex(4'b0001, 3'd1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        cyc(); clr(); ex(4'b0000, 3'd0, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0);
        cyc(); clr(); ex(4'b0000, 3'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        // load-use stall on x7
        cyc(); clr(); sl(0, LW, 7, 1, 0);
        ex(4'b0001, 3'd1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        cyc(); clr(); sl(0, ALU, 8, 7, 0);
        ex(4'b0000, 3'd0, 1'b1, 1'b1, 32'h80, 32'h80, 1'b0);
        cyc();
        cyc(); ex(4'b0001, 3'd1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc(); clr(); ex(4'b0000, 3'd0, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0);
        // single memory port: LW,ADD,SW,ADD -> two issue
        cyc(); clr(); sl(0, LW, 10, 1, 0); sl(1, ALU, 11, 2, 3); sl(2, SW, 0, 4, 12); sl(3, ALU, 13, 14, 15);
        ex(4'b0011, 3'd2, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        cyc(); clr(); ex(4'b0000, 3'd0, 1'b0, 1'b1, 32'hC00, 32'h400, 1'b0);
        cyc(); clr(); ex(4'b0000, 3'd0, 1'b0, 1'b1, 32'h400, 32'h400, 1'b0);
        // branches
        cyc(); clr(); sl(0, BR, 0, 1, 2); sl(1, ALU, 16, 3, 0);
        ex(4'b0001, 3'd1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        cyc(); clr(); sl(0, ALU, 17, 3, 0); sl(1, BR, 0, 4, 5);
        ex(4'b0001, 3'd1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        // intra-group WAW, WAR; slot-1 busy source; full-width issue; slot-1 busy WAW
        cyc(); clr(); sl(0, ALU, 20, 1, 0); sl(1, ALU, 20, 2, 0);
        ex(4'b0001, 3'd1, 1'b0, 1'b1, 32'h20000, 32'h0, 1'b0);
        cyc(); clr(); sl(0, ALU, 21, 22, 0); sl(1, ALU, 22, 1, 0);
        ex(4'b0001, 3'd1, 1'b0, 1'b1, 32'h100000, 32'h0, 1'b0);
        cyc(); clr(); sl(0, ALU, 23, 21, 0); sl(1, ALU, 24, 21, 0);
        ex(4'b0001, 3'd1, 1'b0, 1'b1, 32'h200000, 32'h0, 1'b0);
        cyc(); clr(); sl(0, ALU, 25, 1, 0); sl(1, ALU, 26, 2, 0); sl(2, ALU, 27, 3, 0); sl(3, ALU, 28, 4, 0);
        ex(4'b1111, 3'd4, 1'b0, 1'b1, 32'h800000, 32'h0, 1'b0);
        cyc(); clr(); sl(0, ALU, 1, 2, 0); sl(1, ALU, 25, 0, 0);
        ex(4'b0001, 3'd1, 1'b0, 1'b1, 32'h1E000000, 32'h0, 1'b0);
        cyc(); clr(); sl(0, ALU, 0, 1, 0); sl(1, ALU, 0, 0, 0); sl(2, ALU, 2, 0, 0);
        ex(4'b0111, 3'd3, 1'b0, 1'b1, 32'h2, 32'h0, 1'b0);
        cyc(); clr(); ex(4'b0000, 3'd0, 1'b0, 1'b1, 32'h4, 32'h0, 1'b0);
        cyc(); clr(); sl(1, ALU, 3, 0, 0);
        ex(4'b0000, 3'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        // flush after a load
        cyc(); clr(); sl(0, LW, 9, 1, 0);
        ex(4'b0001, 3'd1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        cyc(); clr(); flush = 1'b1; sl(0, ALU, 3, 2, 0);
        ex(4'b0000, 3'd0, 1'b0, 1'b1, 32'h200, 32'h200, 1'b0);
        cyc(); clr(); flush = 1'b0;
        ex(4'b0000, 3'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        // SYSTEM next to a busy-destination ADD, then halt until reset
        cyc(); clr(); sl(0, ALU, 1, 2, 0);
        ex(4'b0001, 3'd1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        cyc(); clr(); sl(0, ALU, 1, 2, 0); sl(1, SYS, 0, 0, 0);
        ex(4'b0011, 3'd2, 1'b0, 1'b1, 32'h2, 32'h0, 1'b0);
        cyc(); clr(); sl(0, ALU, 4, 0, 0);
        ex(4'b0000, 3'd0, 1'b0, 1'b1, 32'h2, 32'h0, 1'b1);
        cyc(); ex(4'b0000, 3'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; clr(); sl(0, LW, 5, 1, 0);
        ex(4'b0001, 3'd1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        cyc(); clr(); ex(4'b0000, 3'd0, 1'b0, 1'b1, 32'h20, 32'h20, 1'b0);
        repeat (3) cyc();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
